// File: rtl/fixed_ln_seq.sv
// Sequential natural logarithm for sign-magnitude Q16.16 words.
// It produces one log2 fraction bit per cycle by repeated squaring, then scales the result by ln(2).
module fixed_ln_seq #(
    parameter int N = 32,
    parameter int Q = 16,
    parameter logic [N-1:0] LN2 = 32'h0000B172
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         err
);
    localparam int PW = $clog2(N);
    localparam int KW = PW + 1;
    localparam int IW = $clog2(Q);
    localparam int SW = 2 * N;
    localparam int LW = N + 1;

    typedef enum logic [2:0] {IDLE, NORM, ITER, SCALE, DONE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  x_q, x_d;
    logic [N-1:0]  m_q, m_d;
    logic [N-1:0]  result_q, result_d;
    logic [KW-1:0] k_q, k_d;
    logic [Q-1:0]  frac_q, frac_d;
    logic [IW-1:0] i_q, i_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          err_q, err_d;

    logic [N-2:0]  mag;
    logic [PW-1:0] msb_pos;
    logic [PW-1:0] shift_amt;
    logic [SW-1:0] sq;
    logic [N-1:0]  m_sq;
    logic [LW-1:0] l_val;
    logic [LW-1:0] mag_l;
    logic [SW-1:0] prod;
    logic [N-2:0]  prod_mag;
    logic          unused_bits;

    // m is unsigned Q2.30 in [1,2); squaring keeps it in [1,4) after dropping 30 fraction bits
    always_comb begin
        mag = x_q[N-2:0];
        msb_pos = '0;
        for (int j = 0; j < N - 1; j++) begin
            if (mag[j]) msb_pos = PW'(j);
        end
        shift_amt = PW'(N - 2) - msb_pos;
        sq = SW'(m_q) * SW'(m_q);
        m_sq = sq[SW-3 -: N];
        l_val = ({{(LW - KW){k_q[KW-1]}}, k_q} << Q) + LW'(frac_q);
        mag_l = l_val[N] ? (~l_val + LW'(1)) : l_val;
        prod = SW'(mag_l) * SW'(LN2);
        prod_mag = prod[N-2+Q:Q];
        unused_bits = ^{sq[SW-1:SW-2], sq[N-3:0], prod[SW-1:N-1+Q], prod[Q-1:0]};
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        m_d         = m_q;
        result_d    = result_q;
        k_d         = k_q;
        frac_d      = frac_q;
        i_d         = i_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    x_d        = x;
                    in_ready_d = 1'b0;
                    state_d    = NORM;
                end
            end
            NORM: begin
                if (mag == '0) begin
                    err_d    = 1'b1;
                    result_d = '1;
                    state_d  = DONE;
                end else if (x_q[N-1]) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = DONE;
                end else begin
                    err_d   = 1'b0;
                    k_d     = {1'b0, msb_pos} - KW'(Q);
                    m_d     = {1'b0, mag << shift_amt};
                    frac_d  = '0;
                    i_d     = IW'(Q - 1);
                    state_d = ITER;
                end
            end
            ITER: begin
                if (m_sq[N-1]) begin
                    frac_d[i_q] = 1'b1;
                    m_d         = m_sq >> 1;
                end else begin
                    m_d = m_sq;
                end
                if (i_q == '0) state_d = SCALE;
                else           i_d     = i_q - IW'(1);
            end
            SCALE: begin
                // a zero magnitude never carries a sign
                result_d = {l_val[N] && (prod_mag != '0), prod_mag};
                state_d  = DONE;
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            x_q         <= '0;
            m_q         <= '0;
            result_q    <= '0;
            k_q         <= '0;
            frac_q      <= '0;
            i_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            m_q         <= m_d;
            result_q    <= result_d;
            k_q         <= k_d;
            frac_q      <= frac_d;
            i_q         <= i_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign err       = err_q;

endmodule
